// File: rtl/sminmax_pkg.sv
// Shared definitions for the signed extremum tracker: FSM state encoding,
// lane mode selector, default widths and the count saturation helper.
package sminmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic {
    LANE_MAX = 1'b0,
    LANE_MIN = 1'b1
  } lane_mode_t;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_CNTWIDTH  = 8;

  // Largest value an unsigned counter of the given width can hold.
  function automatic int cnt_sat(input int width);
    return (1 << width) - 1;
  endfunction

  localparam int DEF_CNT_SAT = cnt_sat(DEF_CNTWIDTH);

endpackage

// File: rtl/sminmax_track_if.sv
// Sample input and frame result handshakes of the extremum tracker.
// Optional macro: SMINMAX_OVF_EN adds the out_ovf result flag.
interface sminmax_track_if import sminmax_pkg::*; #(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int CNTWIDTH  = DEF_CNTWIDTH
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATAWIDTH-1:0] in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [DATAWIDTH-1:0] max_val;
  logic signed [DATAWIDTH-1:0] min_val;
  logic [CNTWIDTH-1:0]         max_idx;
  logic [CNTWIDTH-1:0]         min_idx;
  logic [CNTWIDTH-1:0]         count;
`ifdef SMINMAX_OVF_EN
  logic                        out_ovf;
`endif

  // Tracker side.
  modport slave (
`ifdef SMINMAX_OVF_EN
    output out_ovf,
`endif
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, max_val, min_val, max_idx, min_idx, count
  );

  // Producer / consumer side.
  modport master (
`ifdef SMINMAX_OVF_EN
    input  out_ovf,
`endif
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, max_val, min_val, max_idx, min_idx, count
  );

endinterface

// File: rtl/sminmax_lane.sv
// One extremum lane: holds the running max (or min) and the index of its
// first occurrence. Strict signed compare, so ties keep the earlier index.
module sminmax_lane import sminmax_pkg::*; #(
  parameter lane_mode_t MODE      = LANE_MAX,
  parameter int         DATAWIDTH = DEF_DATAWIDTH,
  parameter int         CNTWIDTH  = DEF_CNTWIDTH
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        load,
  input  logic                        upd,
  input  logic signed [DATAWIDTH-1:0] data,
  input  logic [CNTWIDTH-1:0]         pos,
  output logic signed [DATAWIDTH-1:0] val,
  output logic [CNTWIDTH-1:0]         idx
);

  logic wins;

  // Does the incoming sample beat the held extremum?
  always_comb begin
    if (MODE == LANE_MAX) wins = (data > val);
    else                  wins = (data < val);
  end

  // First sample of a frame loads unconditionally; later ones only if they win.
  // NOTE: registers use non-blocking assignment so every flop samples
  // pre-edge values, regardless of the order blocks are evaluated in.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      val <= '0;
      idx <= '0;
    end else if (load) begin
      val <= data;
      idx <= '0;
    end else if (upd && wins) begin
      val <= data;
      idx <= pos;
    end
  end

endmodule

// File: rtl/sminmax_track.sv
// Streaming signed extremum tracker: accepts a frame of samples, reports
// max/min, first-occurrence indices and a saturating sample count.
// Optional macro: SMINMAX_OVF_EN adds out_ovf (count saturated this frame).
module sminmax_track import sminmax_pkg::*; #(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int CNTWIDTH  = DEF_CNTWIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  sminmax_track_if.slave   bus
);

  localparam logic [CNTWIDTH-1:0] CNT_SAT = CNTWIDTH'(cnt_sat(CNTWIDTH));

  state_t              state;
  state_t              state_nxt;
  logic                ready;
  logic                accept;
  logic                first;
  logic                more;
  logic [CNTWIDTH-1:0] cnt;

  // Ready depends only on registered state, never on out_ready.
  assign ready  = (state != HOLD);
  assign accept = bus.in_valid && ready;
  assign first  = accept && (state == IDLE);
  assign more   = accept && (state == ACCUM);

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default at the top of the block keeps every path assigned,
  // so no latch is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.in_last ? HOLD : ACCUM;
      ACCUM:   if (accept && bus.in_last) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample counter: restarts at 1 on a frame's first sample, saturates.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt <= '0;
    end else if (first) begin
      cnt <= CNTWIDTH'(1);
    end else if (more && (cnt != CNT_SAT)) begin
      cnt <= cnt + CNTWIDTH'(1);
    end
  end

`ifdef SMINMAX_OVF_EN
  logic ovf;

  // Overflow flag: set by an accept at saturation, cleared when leaving HOLD.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ovf <= 1'b0;
    end else if (first || ((state == HOLD) && bus.out_ready)) begin
      ovf <= 1'b0;
    end else if (more && (cnt == CNT_SAT)) begin
      ovf <= 1'b1;
    end
  end

  assign bus.out_ovf = ovf;
`endif

  // The index of a new extremum is the pre-increment (saturated) count.
  sminmax_lane #(
    .MODE      (LANE_MAX),
    .DATAWIDTH (DATAWIDTH),
    .CNTWIDTH  (CNTWIDTH)
  ) u_max (
    .Clk  (Clk),
    .Rst  (Rst),
    .load (first),
    .upd  (more),
    .data (bus.in_data),
    .pos  (cnt),
    .val  (bus.max_val),
    .idx  (bus.max_idx)
  );

  sminmax_lane #(
    .MODE      (LANE_MIN),
    .DATAWIDTH (DATAWIDTH),
    .CNTWIDTH  (CNTWIDTH)
  ) u_min (
    .Clk  (Clk),
    .Rst  (Rst),
    .load (first),
    .upd  (more),
    .data (bus.in_data),
    .pos  (cnt),
    .val  (bus.min_val),
    .idx  (bus.min_idx)
  );

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.count     = cnt;

endmodule

// File: tb/tb_sminmax_track.sv
// Directed bench for sminmax_track: one 8/8 instance for the main frames and
// one 8/3 instance for counter saturation. Inputs change on the falling
// edge; outputs are checked on the falling edge.
module tb_sminmax_track;

  logic Clk;
  logic Rst;
  int   total = 0;
  int   bad   = 0;

  sminmax_track_if #(.DATAWIDTH(8), .CNTWIDTH(8)) a_if ();
  sminmax_track_if #(.DATAWIDTH(8), .CNTWIDTH(3)) b_if ();

  sminmax_track #(.DATAWIDTH(8), .CNTWIDTH(8)) dut_a (
    .Clk (Clk),
    .Rst (Rst),
    .bus (a_if.slave)
  );

  sminmax_track #(.DATAWIDTH(8), .CNTWIDTH(3)) dut_b (
    .Clk (Clk),
    .Rst (Rst),
    .bus (b_if.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample from a falling edge and return on the falling edge
  // after it was accepted.
  task automatic send(input bit to_b, input logic signed [7:0] d, input logic l);
    int n;
    n = 0;
    if (to_b) begin
      b_if.in_valid = 1'b1; b_if.in_data = d; b_if.in_last = l;
      while (!b_if.in_ready && n < 50) begin @(negedge Clk); n++; end
      if (n >= 50) check("send_b_timeout", b_if.in_ready, 1);
    end else begin
      a_if.in_valid = 1'b1; a_if.in_data = d; a_if.in_last = l;
      while (!a_if.in_ready && n < 50) begin @(negedge Clk); n++; end
      if (n >= 50) check("send_a_timeout", a_if.in_ready, 1);
    end
    @(negedge Clk);
    a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_last = 1'b0;
  endtask

  task automatic check_a(input string tag, input longint mx, input longint mxi,
                         input longint mn, input longint mni, input longint cn);
    check({tag, "_valid"},   a_if.out_valid, 1);
    check({tag, "_ready"},   a_if.in_ready,  0);
    check({tag, "_max"},     a_if.max_val,   mx);
    check({tag, "_max_idx"}, a_if.max_idx,   mxi);
    check({tag, "_min"},     a_if.min_val,   mn);
    check({tag, "_min_idx"}, a_if.min_idx,   mni);
    check({tag, "_count"},   a_if.count,     cn);
  endtask

  // One-cycle out_ready pulse, then confirm the block is back in IDLE.
  task automatic consume_a(input string tag);
    a_if.out_ready = 1'b1;
    @(negedge Clk);
    a_if.out_ready = 1'b0;
    check({tag, "_drop_valid"}, a_if.out_valid, 0);
    check({tag, "_ready_back"}, a_if.in_ready,  1);
  endtask

  initial begin
    Rst = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_last = 1'b0; b_if.out_ready = 1'b0;
    repeat (3) @(negedge Clk);

    // Reset state.
    check("rst_valid",   a_if.out_valid, 0);
    check("rst_max",     a_if.max_val,   0);
    check("rst_min",     a_if.min_val,   0);
    check("rst_max_idx", a_if.max_idx,   0);
    check("rst_min_idx", a_if.min_idx,   0);
    check("rst_count",   a_if.count,     0);
    Rst = 1'b1;
    @(negedge Clk);
    check("rst_ready", a_if.in_ready, 1);

    // Frame 3,-5,7,-5,7: ties with the extremum keep the earlier index.
    send(0, 8'sd3, 0);
    send(0, -8'sd5, 0);
    send(0, 8'sd7, 0);
    send(0, -8'sd5, 0);
    send(0, 8'sd7, 1);
    check_a("f1", 7, 2, -5, 1, 5);
    consume_a("f1");

    // Single most-negative sample.
    send(0, -8'sd128, 1);
    check_a("f2", -128, 0, -128, 0, 1);

    // Back-pressure in HOLD with a sample waiting: nothing is consumed.
    a_if.in_valid = 1'b1; a_if.in_data = 8'sd99; a_if.in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("hold_ready", a_if.in_ready,  0);
      check("hold_valid", a_if.out_valid, 1);
      check("hold_max",   a_if.max_val,   -128);
      check("hold_count", a_if.count,     1);
    end
    a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
    consume_a("f2");

    // Next frame after the stall starts cleanly.
    send(0, 8'sd4, 0);
    send(0, 8'sd6, 1);
    check_a("f3", 6, 1, 4, 0, 2);
    consume_a("f3");

    // Reset in the middle of a frame discards it.
    send(0, 8'sd10, 0);
    send(0, 8'sd20, 0);
    Rst = 1'b0;
    #1;
    check("mid_rst_max",   a_if.max_val,   0);
    check("mid_rst_min",   a_if.min_val,   0);
    check("mid_rst_count", a_if.count,     0);
    check("mid_rst_valid", a_if.out_valid, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    send(0, 8'sd1, 0);
    send(0, 8'sd2, 1);
    check_a("f4", 2, 1, 1, 0, 2);
    consume_a("f4");

    // Frame with a three-cycle bubble.
    send(0, 8'sd5, 0);
    repeat (3) @(negedge Clk);
    check("bubble_ready", a_if.in_ready,  1);
    check("bubble_valid", a_if.out_valid, 0);
    send(0, 8'sd127, 0);
    send(0, -8'sd1, 1);
    check_a("f6", 127, 1, -1, 2, 3);
    consume_a("f6");

    // Saturation with a 3-bit counter: nine samples, max 50 at position 8.
    for (int i = 1; i <= 8; i++) send(1, 8'(i), 0);
    send(1, 8'sd50, 1);
    check("sat_valid",   b_if.out_valid, 1);
    check("sat_count",   b_if.count,     7);
    check("sat_max",     b_if.max_val,   50);
    check("sat_max_idx", b_if.max_idx,   7);
    check("sat_min",     b_if.min_val,   1);
    check("sat_min_idx", b_if.min_idx,   0);
`ifdef SMINMAX_OVF_EN
    check("sat_ovf", b_if.out_ovf, 1);
`endif
    b_if.out_ready = 1'b1;
    @(negedge Clk);
    b_if.out_ready = 1'b0;
    check("sat_drop_valid", b_if.out_valid, 0);
`ifdef SMINMAX_OVF_EN
    check("sat_ovf_clear", b_if.out_ovf, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
